// File: rtl/pio_tctrl.sv
`timescale 1ns/1ps
// PIO access timing controller: sequences one ATA PIO transfer through the
// address-setup (T1), strobe (T2, IORDY-extended) and end-of-cycle phases.
module pio_tctrl #(
  parameter int unsigned TWIDTH = 8
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              rst,
  input  logic [TWIDTH-1:0] t1,
  input  logic [TWIDTH-1:0] t2,
  input  logic [TWIDTH-1:0] teoc,
  input  logic              go,
  input  logic              we,
  input  logic              iordy,
  output logic              busy,
  output logic              dior,
  output logic              diow,
  output logic              oe,
  output logic              store,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_TEOC = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TWIDTH-1:0] cnt_q, cnt_d;
  logic [TWIDTH-1:0] t2_q, t2_d;
  logic [TWIDTH-1:0] teoc_q, teoc_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              dior_q, dior_d;
  logic              diow_q, diow_d;
  logic              oe_q, oe_d;
  logic              cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Next state, phase counter and access-parameter latches
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t2_d    = t2_q;
    teoc_d  = teoc_q;
    we_d    = we_q;

    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_T1;
          cnt_d   = t1;
          we_d    = we;
          t2_d    = t2;
          teoc_d  = teoc;
        end
      end
      ST_T1: begin
        if (cnt_zero) begin
          state_d = ST_T2;
          cnt_d   = t2_q;
        end else begin
          cnt_d = cnt_q - TWIDTH'(1);
        end
      end
      ST_T2: begin
        // At terminal count the counter parks at zero until IORDY arrives
        if (!cnt_zero) begin
          cnt_d = cnt_q - TWIDTH'(1);
        end else if (iordy) begin
          state_d = ST_TEOC;
          cnt_d   = teoc_q;
        end
      end
      ST_TEOC: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - TWIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      t2_d    = '0;
      teoc_d  = '0;
      we_d    = 1'b0;
    end
  end

  // Strobe/enable outputs are decoded from the next state so they line up with it
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    oe_d   = busy_d & we_d;
    dior_d = (state_d == ST_T2) & ~we_d;
    diow_d = (state_d == ST_T2) & we_d;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      t2_q    <= '0;
      teoc_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      dior_q  <= 1'b0;
      diow_q  <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t2_q    <= t2_d;
      teoc_q  <= teoc_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      dior_q  <= dior_d;
      diow_q  <= diow_d;
      oe_q    <= oe_d;
    end
  end

  assign busy = busy_q;
  assign dior = dior_q;
  assign diow = diow_q;
  assign oe   = oe_q;

  // A synchronously aborted access must not emit its capture or completion pulse
  assign store = ~rst & (state_q == ST_T2) & cnt_zero & iordy & ~we_q;
  assign done  = ~rst & (state_q == ST_TEOC) & cnt_zero;

endmodule

// File: tb/tb_pio_tctrl.sv
`timescale 1ns/1ps
// Bench for pio_tctrl: directed and randomized PIO accesses checked cycle by
// cycle against a phase-boundary arithmetic model.
module tb_pio_tctrl;

  localparam int unsigned TW = 8;

  logic          clk = 1'b0;
  logic          nReset = 1'b0;
  logic          rst = 1'b0;
  logic [TW-1:0] t1 = '0;
  logic [TW-1:0] t2 = '0;
  logic [TW-1:0] teoc = '0;
  logic          go = 1'b0;
  logic          we = 1'b0;
  logic          iordy = 1'b1;
  logic          busy, dior, diow, oe, store, done;

  int checks = 0;
  int failures = 0;

  pio_tctrl #(.TWIDTH(TW)) dut (
    .clk    (clk),
    .nReset (nReset),
    .rst    (rst),
    .t1     (t1),
    .t2     (t2),
    .teoc   (teoc),
    .go     (go),
    .we     (we),
    .iordy  (iordy),
    .busy   (busy),
    .dior   (dior),
    .diow   (diow),
    .oe     (oe),
    .store  (store),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Output vector order: {busy, dior, diow, oe, store, done}
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {busy, dior, diow, oe, store, done};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (busy,dior,diow,oe,store,done)", tag, obs, exp);
    end
  endtask

  // Expected outputs from phase boundaries: T1 ends at a1+1, T2 at a1+a2+2+w,
  // done at a1+a2+ae+3+w. Called at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic run_access(input int a1, input int a2, input int ae,
                            input logic aw, input int w, input string nm);
    int   t1end, t2end, total;
    logic in_t1, in_t2, bsy;
    logic [5:0] exp;
    t1end = a1 + 1;
    t2end = a1 + a2 + 2 + w;
    total = t2end + ae + 1;
    go   = 1'b1;
    we   = aw;
    t1   = TW'(a1);
    t2   = TW'(a2);
    teoc = TW'(ae);
    @(posedge clk); #1;
    for (int k = 1; k <= total + 1; k++) begin
      // Everything except the T2 terminal-count iordy is scrambled and must be ignored
      go   = (k == total + 1) ? 1'b0 : 1'($urandom);
      we   = 1'($urandom);
      t1   = TW'($urandom);
      t2   = TW'($urandom);
      teoc = TW'($urandom);
      if (k >= a1 + a2 + 2 && k < t2end) iordy = 1'b0;
      else if (k == t2end)               iordy = 1'b1;
      else                               iordy = 1'($urandom);
      @(negedge clk);
      in_t1 = (k <= t1end);
      in_t2 = !in_t1 && (k <= t2end);
      bsy   = (k <= total);
      exp = {bsy, in_t2 & ~aw, in_t2 & aw, bsy & aw, (k == t2end) & ~aw, (k == total)};
      chk($sformatf("%s_c%0d", nm, k), exp);
      if (k <= total) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held, then released with go low: quiet for 20 cycles
    repeat (3) @(negedge clk);
    chk("in_reset", 6'b000000);
    nReset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle_after_reset_%0d", i), 6'b000000);
    end

    run_access(2, 3, 1, 1'b1, 0, "wr_2_3_1");
    run_access(0, 0, 0, 1'b0, 0, "rd_min");
    run_access(1, 2, 2, 1'b0, 5, "rd_iordy_wait");
    run_access(0, 0, 255, 1'b1, 0, "wr_teoc_max");
    run_access(0, 255, 0, 1'b0, 2, "rd_t2_max");

    // Back-to-back accesses with randomized timing, direction and IORDY stretch
    for (int n = 0; n < 30; n++) begin
      run_access(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 5)), 1'($urandom),
                 int'($urandom_range(0, 4)), $sformatf("rand%0d", n));
    end

    // Async reset mid-T2 of a write: strobe drops without a clock edge
    go = 1'b1; we = 1'b1; t1 = '0; t2 = TW'(5); teoc = '0;
    @(posedge clk); #1;
    go = 1'b0; iordy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("nrst_pre_t2", 6'b101100);
    #2;
    nReset = 1'b0;
    #1;
    chk("nrst_async_clear", 6'b000000);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    chk("nrst_idle", 6'b000000);
    run_access(1, 1, 1, 1'b0, 1, "post_nrst");

    // Sync reset in a middle TEOC cycle of a read
    go = 1'b1; we = 1'b0; t1 = '0; t2 = '0; teoc = TW'(3);
    @(posedge clk); #1;
    go = 1'b0; iordy = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_teoc_c4", 6'b100000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_teoc_c5", 6'b000000);
    @(negedge clk);
    chk("rst_teoc_c6_no_done", 6'b000000);

    // Sync reset in the final TEOC cycle suppresses done
    go = 1'b1; we = 1'b0; t1 = '0; t2 = '0; teoc = TW'(3);
    @(posedge clk); #1;
    go = 1'b0; iordy = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_last_teoc_no_done", 6'b100000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_last_teoc_idle", 6'b000000);

    run_access(0, 1, 0, 1'b1, 3, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
